// File: rtl/dsa_simd_write_packer.sv
// Write packer for the banked output memory: turns a byte-wide pixel stream into
// 4-lane aligned SIMD writes, with single-byte writes for unaligned head and short tail.
module dsa_simd_write_packer #(
   parameter int ADDR_WIDTH = 18
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] dst_base_addr,
   input  logic [ADDR_WIDTH:0]   pix_count,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [7:0]            in_data,
   output logic                  simd_write_en,
   output logic [ADDR_WIDTH-1:0] simd_base_addr,
   output logic [7:0]            simd_data_0,
   output logic [7:0]            simd_data_1,
   output logic [7:0]            simd_data_2,
   output logic [7:0]            simd_data_3,
   output logic                  write_en,
   output logic [ADDR_WIDTH-1:0] write_addr,
   output logic [7:0]            write_data,
   output logic                  busy,
   output logic                  done
);

   typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

   state_t                state, state_nxt;
   logic [ADDR_WIDTH-1:0] cur_addr;
   logic [ADDR_WIDTH:0]   remaining;
   logic [1:0]            lane_idx;
   logic [2:0][7:0]       lanes;
   logic                  accept;
   logic                  group_mode;

   assign accept = in_valid && in_ready;
   // An open group stays in group mode until its 4th pixel, regardless of remaining.
   assign group_mode = (lane_idx != 2'd0) ||
                       ((cur_addr[1:0] == 2'b00) && (remaining >= (ADDR_WIDTH+1)'(4)));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_nxt = (pix_count != '0) ? RUN : FIN;
         end
         RUN: begin
            in_ready = 1'b1;
            busy     = 1'b1;
            if (in_valid && (remaining == (ADDR_WIDTH+1)'(1))) state_nxt = FIN;
         end
         FIN: begin
            busy      = 1'b1;
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur_addr       <= '0;
         remaining      <= '0;
         lane_idx       <= 2'd0;
         lanes          <= '0;
         simd_write_en  <= 1'b0;
         simd_base_addr <= '0;
         simd_data_0    <= 8'd0;
         simd_data_1    <= 8'd0;
         simd_data_2    <= 8'd0;
         simd_data_3    <= 8'd0;
         write_en       <= 1'b0;
         write_addr     <= '0;
         write_data     <= 8'd0;
      end else begin
         simd_write_en <= 1'b0;
         write_en      <= 1'b0;
         if (state == IDLE && start) begin
            cur_addr  <= dst_base_addr;
            remaining <= pix_count;
            lane_idx  <= 2'd0;
         end else if (accept) begin
            cur_addr  <= cur_addr + ADDR_WIDTH'(1);
            remaining <= remaining - (ADDR_WIDTH+1)'(1);
            if (group_mode) begin
               if (lane_idx == 2'd3) begin
                  simd_write_en  <= 1'b1;
                  simd_base_addr <= {cur_addr[ADDR_WIDTH-1:2], 2'b00};
                  simd_data_0    <= lanes[0];
                  simd_data_1    <= lanes[1];
                  simd_data_2    <= lanes[2];
                  simd_data_3    <= in_data;
                  lane_idx       <= 2'd0;
               end else begin
                  lanes[lane_idx] <= in_data;
                  lane_idx        <= lane_idx + 2'd1;
               end
            end else begin
               write_en   <= 1'b1;
               write_addr <= cur_addr;
               write_data <= in_data;
            end
         end
      end
   end

endmodule

// File: doc/dsa_simd_write_packer.md
# dsa_simd_write_packer

Upstream write stage for the banked output memory. Accepts the interpolated pixel stream one byte at a time with a valid/ready handshake and computes sequential destination addresses from a frame base. Packs every 4-aligned group of 4 pixels into one SIMD write across the 4 banks. Head pixels before the first aligned address and tail pixels of a short final group go through the single-byte write port.

## Interface
Parameters:
- ADDR_WIDTH, 18, byte address width; matches the banked memory.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a frame; sampled only in IDLE.
- dst_base_addr  in  ADDR_WIDTH  first destination byte address; sampled on start.
- pix_count  in  ADDR_WIDTH+1  number of pixels in the frame; sampled on start.
- in_valid  in  1  pixel present on in_data.
- in_ready  out  1  packer accepts a pixel this cycle.
- in_data  in  8  pixel value.
- simd_write_en  out  1  one-cycle strobe for a 4-lane write.
- simd_base_addr  out  ADDR_WIDTH  4-aligned address of the group; bits [1:0] always 0.
- simd_data_0..simd_data_3  out  8 each  lane k holds the pixel destined for simd_base_addr+k.
- write_en  out  1  one-cycle strobe for a single-byte write.
- write_addr  out  ADDR_WIDTH  single-write address.
- write_data  out  8  single-write data.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse when the frame is complete.

## Operation
- States: IDLE, RUN, FIN.
- IDLE:
  - in_ready=0.
  - On start, latch cur_addr=dst_base_addr, remaining=pix_count and clear lane_idx.
  - Go to RUN if pix_count≠0, otherwise go to FIN.
- RUN:
  - in_ready=1.
  - A pixel is accepted on in_valid&&in_ready. There is at most one accept per cycle and no backpressure from memory.
- Mode decision, made when lane_idx==0 at each accepted pixel:
  - Group mode if cur_addr[1:0]==0 and remaining≥4.
  - Otherwise single mode.
- Group mode:
  - Pixel is stored in lane[lane_idx], then lane_idx increments.
  - On the 4th pixel, register simd_write_en=1, simd_base_addr=cur_addr & ~3, and all 4 lanes; then clear lane_idx.
- Single mode: register write_en=1, write_addr=cur_addr, write_data=in_data.
- Every accept: cur_addr+=1, wrapping modulo 2^ADDR_WIDTH; remaining-=1.
- When the pixel that brings remaining to 0 is accepted, go to FIN.
- FIN:
  - done=1 for exactly one cycle, then return to IDLE.
  - busy stays 1 through FIN and is 0 in IDLE.
- simd_write_en and write_en are never high in the same cycle, because each accepted pixel produces at most one strobe.
- start in RUN or FIN is ignored.
- in_valid gaps inside a group are allowed. Partially filled lanes are held with no timeout.
- Lane registers and data/address outputs hold their last value when strobes are low.

## Timing
- Reset values: in_ready, simd_write_en, write_en, busy and done are 0; all address and data outputs are 0; state=IDLE, lane_idx=0.
- Reset asserted mid-frame aborts immediately. Captured lanes are discarded and no write is issued.
- start at cycle T:
  - busy=1 and in_ready=1 from T+1.
  - With pix_count=0: FIN at T+1, done at T+1, busy=0 at T+2.
- Write latency: a strobe is high in cycle A+1, where A is the accept cycle of the pixel that completes the single write or the 4-lane group.
- The final pixel accepted at cycle A gives:
  - final strobe at A+1;
  - done at A+1, concurrent with the final strobe;
  - in_ready=0 from A+1;
  - IDLE at A+2.
- Throughput: 1 pixel/cycle sustained; a SIMD strobe every 4 cycles under continuous valid.

## Test plan
- Aligned frame: base 0x00100, 8 pixels 0x10..0x17, continuous valid.
  - Expect SIMD at 0x00100 with lanes 10,11,12,13.
  - Expect SIMD at 0x00104 with lanes 14,15,16,17.
  - Expect no write_en.
  - done is coincident with the 2nd strobe.
- Unaligned frame: base 0x00102, 7 pixels A0..A6.
  - Expect single 0x00102=A0, single 0x00103=A1.
  - Expect SIMD 0x00104 with lanes A2,A3,A4,A5.
  - Expect single 0x00108=A6, then done.
- Short aligned frame: base 0x00200, 3 pixels.
  - Expect 3 single writes at 0x00200..0x00202 and zero SIMD strobes.
- Stalled group: base 0, 4 pixels with in_valid low for 3 cycles between each pixel.
  - Expect exactly one SIMD strobe, one cycle after the 4th accept, with correct lane order.
- Wrap and edge cases:
  - Base 0x3FFFC, 8 pixels: expect SIMD at 0x3FFFC, then SIMD at 0x00000.
  - pix_count=0: expect done at T+1 and no writes.
  - start pulsed mid-frame: ignored.
- Reset abort: assert rst_n=0 after 2 pixels of a group.
  - All outputs go to 0 immediately.
  - No strobe after release.
  - A new start then runs a clean frame.
